// File: rtl/tqvp_crc32_pkg.sv
// Shared constants, state encoding and bit-reversal helpers for the CRC-32 checker.
package tqvp_crc32_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_CONFIG = 6'h04;
  localparam logic [5:0] ADDR_DATA   = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_POLY   = 6'h10;
  localparam logic [5:0] ADDR_CALC   = 6'h14;
  localparam logic [5:0] ADDR_RXCRC  = 6'h18;
  localparam logic [5:0] ADDR_LEN    = 6'h1C;

  localparam int CTRL_START   = 0;
  localparam int CTRL_END     = 1;
  localparam int CTRL_IRQ_CLR = 2;

  localparam int CFG_REFIN  = 0;
  localparam int CFG_REFOUT = 1;
  localparam int CFG_INIT   = 2;
  localparam logic [2:0] CFG_RESET = 3'b111;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_MATCH    = 2;
  localparam int ST_MISMATCH = 3;
  localparam int ST_OVF      = 4;
  localparam int ST_SHORT    = 5;

  localparam logic [31:0] CRC_INIT_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR_OUT   = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_POLY  = 32'h04C1_1DB7;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FINAL, S_DONE} state_t;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
  endfunction

endpackage

// File: rtl/tqvp_crc32_bitserial.sv
// MSB-first bit-serial CRC engine: one byte per start pulse, one bit per cycle.
module tqvp_crc32_bitserial import tqvp_crc32_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_init,
  input  logic [31:0] init_val,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        refin,
  input  logic [31:0] poly,
  output logic [31:0] crc,
  output logic        busy
);
  logic [7:0] shreg;
  logic [3:0] bits_left;
  logic       fb;

  assign busy = (bits_left != 4'd0);
  assign fb   = crc[31] ^ shreg[7];

  // Load init, latch a byte (reflected if requested), then shift 8 bits through the LFSR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc       <= 32'h0;
      shreg     <= 8'h00;
      bits_left <= 4'd0;
    end else if (load_init) begin
      crc       <= init_val;
      shreg     <= 8'h00;
      bits_left <= 4'd0;
    end else if (start && !busy) begin
      shreg     <= refin ? rev8(byte_in) : byte_in;
      bits_left <= 4'd8;
    end else if (busy) begin
      crc       <= {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0);
      shreg     <= {shreg[6:0], 1'b0};
      bits_left <= bits_left - 4'd1;
    end
  end

endmodule

// File: rtl/tqvp_crc32_checker.sv
// Receive-side CRC-32 checker: byte FIFO, 4-byte hold-back delay line,
// bit-serial engine and the TinyQV register interface.
module tqvp_crc32_checker import tqvp_crc32_pkg::*; #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DEFAULT_POLY = tqvp_crc32_pkg::DEFAULT_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t        state;
  logic [2:0]    cfg;
  logic [31:0]   poly, calc, rxcrc, dline;
  logic [2:0]    fill;
  logic [15:0]   len;
  logic          done, match, mismatch, ovf, short_frame, irq, busy;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [7:0]    fifo_q;

  logic [3:0]    be;
  logic          ctrl_wr, start_p, end_p, irqclr_p, data_wr;
  logic          fifo_full, push, pop, feed, fin_go, fin_match;
  logic          eng_busy;
  logic [31:0]   eng_crc, calc_next, status;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in};

  // Byte enables from the access width encoding
  always_comb begin
    be = 4'b0000;
    case (data_write_n)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign ctrl_wr   = be[0] && (address == ADDR_CTRL);
  assign start_p   = ctrl_wr && data_in[CTRL_START];
  assign end_p     = ctrl_wr && data_in[CTRL_END] && !start_p;
  assign irqclr_p  = ctrl_wr && data_in[CTRL_IRQ_CLR];
  assign data_wr   = be[0] && (address == ADDR_DATA);

  assign fifo_full = (cnt == CW'(FIFO_DEPTH));
  assign fifo_q    = mem[rp];
  assign busy      = (state == S_ACTIVE) || (state == S_FINAL);
  assign push      = data_wr && (state == S_ACTIVE) && !fifo_full;
  // Queued bytes keep draining in FINAL so nothing sent before END is lost
  assign pop       = busy && (cnt != '0) && !eng_busy && !start_p;
  // Only a byte that pushes an older one out of a full delay line is payload
  assign feed      = pop && (fill == 3'd4);
  assign fin_go    = (state == S_FINAL) && (cnt == '0) && !eng_busy;
  assign calc_next = cfg[CFG_REFOUT] ? (rev32(eng_crc) ^ CRC_XOR_OUT) : eng_crc;
  assign fin_match = (fill == 3'd4) && (calc_next == dline);

  tqvp_crc32_bitserial u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_init (start_p),
    .init_val  (cfg[CFG_INIT] ? CRC_INIT_ONES : 32'h0),
    .start     (feed),
    .byte_in   (dline[7:0]),
    .refin     (cfg[CFG_REFIN]),
    .poly      (poly),
    .crc       (eng_crc),
    .busy      (eng_busy)
  );

  // Input byte FIFO; START discards anything left over from an earlier frame
  always_ff @(posedge clk) begin
    if (!rst_n || start_p) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wp] <= data_in[7:0];
        wp      <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (pop) rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Frame FSM with delay line, payload length, result flags and interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cfg         <= CFG_RESET;
      poly        <= DEFAULT_POLY;
      dline       <= 32'h0;
      fill        <= 3'd0;
      len         <= 16'h0;
      calc        <= 32'h0;
      rxcrc       <= 32'h0;
      done        <= 1'b0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      ovf         <= 1'b0;
      short_frame <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (be[0] && (address == ADDR_CONFIG) && ((state == S_IDLE) || (state == S_DONE)))
        cfg <= data_in[2:0];
      if (address == ADDR_POLY)
        for (int i = 0; i < 4; i++)
          if (be[i]) poly[8*i +: 8] <= data_in[8*i +: 8];
      if (data_wr && (state == S_ACTIVE) && fifo_full) ovf <= 1'b1;
      // Newest byte enters at the top so the oldest sits in [7:0]
      if (pop) begin
        dline <= {fifo_q, dline[31:8]};
        if (fill != 3'd4)        fill <= fill + 3'd1;
        else if (len != 16'hFFFF) len <= len + 16'd1;
      end
      if (fin_go)                     irq <= 1'b1;
      else if (start_p || irqclr_p)   irq <= 1'b0;
      case (state)
        S_ACTIVE: if (end_p) state <= S_FINAL;
        S_FINAL: if (fin_go) begin
          state       <= S_DONE;
          calc        <= calc_next;
          rxcrc       <= dline;
          done        <= 1'b1;
          short_frame <= (fill != 3'd4);
          match       <= fin_match;
          mismatch    <= !fin_match;
        end
        default: ;
      endcase
      if (start_p) begin
        state       <= S_ACTIVE;
        dline       <= 32'h0;
        fill        <= 3'd0;
        len         <= 16'h0;
        done        <= 1'b0;
        match       <= 1'b0;
        mismatch    <= 1'b0;
        ovf         <= 1'b0;
        short_frame <= 1'b0;
      end
    end
  end

  // Combinational register read mux
  always_comb begin
    status              = 32'h0;
    status[ST_BUSY]     = busy;
    status[ST_DONE]     = done;
    status[ST_MATCH]    = match;
    status[ST_MISMATCH] = mismatch;
    status[ST_OVF]      = ovf;
    status[ST_SHORT]    = short_frame;
    status[11:8]        = 4'(cnt);
    data_out = 32'h0;
    case (address)
      ADDR_CONFIG: data_out = {29'h0, cfg};
      ADDR_STATUS: data_out = status;
      ADDR_POLY:   data_out = poly;
      ADDR_CALC:   data_out = calc;
      ADDR_RXCRC:  data_out = rxcrc;
      ADDR_LEN:    data_out = {16'h0, len};
      default:     data_out = 32'h0;
    endcase
  end

  // CALC is not valid until finalisation completes
  assign data_ready     = !((data_read_n != 2'b11) && (address == ADDR_CALC) && (state == S_FINAL));
  assign uo_out         = {6'b0, mismatch, match};
  assign user_interrupt = irq;

endmodule

// File: tb/tb_tqvp_crc32_checker.sv
// Directed + randomized frames against a bytewise CRC reference model.
module tb_tqvp_crc32_checker;
  localparam logic [5:0] A_CTRL = 6'h00, A_CONFIG = 6'h04, A_DATA = 6'h08, A_STATUS = 6'h0C,
                         A_POLY = 6'h10, A_CALC = 6'h14, A_RXCRC = 6'h18, A_LEN = 6'h1C;
  localparam logic [31:0] POLY0 = 32'h04C11DB7;
  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00, uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0, data_out;
  logic [1:0]  data_write_n = 2'b11, data_read_n = 2'b11;
  logic        data_ready, user_interrupt;
  int          vecs = 0, errs = 0;

  tqvp_crc32_checker dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] brev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reflected configs use the LSB-first table-less form with the mirrored polynomial
  function automatic logic [31:0] ref_crc(input bq_t msg, input logic [2:0] cfg, input logic [31:0] poly);
    logic [31:0] r, rp;
    r = cfg[2] ? 32'hFFFFFFFF : 32'h0;
    if (cfg[0]) begin
      rp = brev(poly);
      foreach (msg[i]) begin
        r = r ^ {24'h0, msg[i]};
        repeat (8) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
      end
      return cfg[1] ? (r ^ 32'hFFFFFFFF) : brev(r);
    end else begin
      foreach (msg[i]) begin
        r = r ^ {msg[i], 24'h0};
        repeat (8) r = r[31] ? ((r << 1) ^ poly) : (r << 1);
      end
      return cfg[1] ? (brev(r) ^ 32'hFFFFFFFF) : r;
    end
  endfunction

  function automatic logic [31:0] rx_of(input bq_t f);
    int n = f.size();
    return {f[n-1], f[n-2], f[n-3], f[n-4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    address = a; data_in = d; data_write_n = w;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic r);
    address = a; data_read_n = 2'b10;
    #1;
    d = data_out; r = data_ready;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic rdchk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d; logic r;
    rd(a, d, r);
    chk(tag, d, exp);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d; logic r; int n;
    n = 0;
    rd(A_STATUS, d, r);
    while (!d[1] && n < 1000) begin rd(A_STATUS, d, r); n++; end
    chk({tag, "_done"}, {31'h0, d[1]}, 32'h1);
  endtask

  task automatic send_bytes(input bq_t f);
    foreach (f[i]) begin
      wr(A_DATA, {24'h0, f[i]}, 2'b00);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input bq_t f);
    wr(A_CTRL, 32'h1, 2'b00);
    send_bytes(f);
    wr(A_CTRL, 32'h2, 2'b00);
    wait_done(tag);
  endtask

  initial begin
    bq_t msg, f, pay, acc, w;
    logic [31:0] d, e, rx, poly;
    logic [2:0]  cfg;
    logic        r, bad, m;
    int          n;

    for (int i = 1; i <= 9; i++) msg.push_back(8'(8'h30 + i));
    repeat (3) @(negedge clk);

    // Reset state
    rdchk("rst_status", A_STATUS, 32'h0);
    rdchk("rst_config", A_CONFIG, 32'h7);
    rdchk("rst_poly", A_POLY, POLY0);
    rd(A_CALC, d, r);
    chk("rst_calc", d, 32'h0);
    chk("rst_rdy", {31'h0, r}, 32'h1);
    chk("rst_uo", {24'h0, uo_out}, 32'h0);
    chk("rst_irq", {31'h0, user_interrupt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: standard CRC-32 check frame
    f = msg; f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    run_frame("t1", f);
    rdchk("t1_status", A_STATUS, 32'h06);
    rdchk("t1_calc", A_CALC, 32'hCBF43926);
    rdchk("t1_rxcrc", A_RXCRC, 32'hCBF43926);
    rdchk("t1_len", A_LEN, 32'd9);
    chk("t1_uo", {24'h0, uo_out}, 32'h01);
    chk("t1_irq", {31'h0, user_interrupt}, 32'h1);
    wr(A_CTRL, 32'h4, 2'b00);
    chk("t1_irqclr", {31'h0, user_interrupt}, 32'h0);

    // Test 2: corrupted last CRC byte
    f[12] = 8'hCC;
    run_frame("t2", f);
    rdchk("t2_status", A_STATUS, 32'h0A);
    rdchk("t2_rxcrc", A_RXCRC, 32'hCCF43926);
    rdchk("t2_calc", A_CALC, 32'hCBF43926);
    chk("t2_uo", {24'h0, uo_out}, 32'h02);

    // Test 3: short frame
    f = {}; f.push_back(8'hA1); f.push_back(8'hB2); f.push_back(8'hC3);
    run_frame("t3", f);
    rdchk("t3_status", A_STATUS, 32'h2A);
    rdchk("t3_len", A_LEN, 32'd0);
    pay = {};
    rdchk("t3_calc", A_CALC, ref_crc(pay, 3'b111, POLY0));

    // Randomized frames: random config, polynomial, payload and corruption
    for (int k = 0; k < 5; k++) begin
      cfg  = 3'($urandom_range(0, 7));
      poly = $urandom | 32'h1;
      n    = $urandom_range(0, 10);
      wr(A_CONFIG, {29'h0, cfg}, 2'b00);
      wr(A_POLY, poly, 2'b10);
      pay = {};
      repeat (n) pay.push_back(8'($urandom));
      e = ref_crc(pay, cfg, poly);
      f = pay;
      for (int b = 0; b < 4; b++) f.push_back(e[8*b +: 8]);
      bad = 1'($urandom_range(0, 1));
      if (bad) f[n + $urandom_range(0, 3)] ^= 8'h01;
      run_frame("rnd", f);
      rdchk("rnd_calc", A_CALC, e);
      rdchk("rnd_rxcrc", A_RXCRC, rx_of(f));
      rdchk("rnd_status", A_STATUS, bad ? 32'h0A : 32'h06);
      rdchk("rnd_len", A_LEN, n);
    end

    // Test 4: overflow from back-to-back DATA writes, CALC stalled during FINAL
    wr(A_CONFIG, 32'h7, 2'b00);
    wr(A_POLY, POLY0, 2'b10);
    wr(A_CTRL, 32'h1, 2'b00);
    acc = {}; w = {};
    repeat (4) acc.push_back(8'($urandom));
    send_bytes(acc);
    repeat (6) w.push_back(8'($urandom));
    foreach (w[i]) wr(A_DATA, {24'h0, w[i]}, 2'b00);
    for (int i = 0; i < 5; i++) acc.push_back(w[i]);
    rd(A_STATUS, d, r);
    chk("t4_count", {28'h0, d[11:8]}, 32'd4);
    chk("t4_ovf", {31'h0, d[4]}, 32'h1);
    wr(A_CTRL, 32'h2, 2'b00);
    rd(A_CALC, d, r);
    chk("t4_rdy_low", {31'h0, r}, 32'h0);
    n = 0;
    while (!r && n < 300) begin rd(A_CALC, d, r); n++; end
    chk("t4_rdy_high", {31'h0, r}, 32'h1);
    pay = {};
    for (int i = 0; i < 5; i++) pay.push_back(acc[i]);
    e  = ref_crc(pay, 3'b111, POLY0);
    rx = rx_of(acc);
    m  = (e == rx);
    chk("t4_calc", d, e);
    rdchk("t4_rxcrc", A_RXCRC, rx);
    rdchk("t4_len", A_LEN, 32'd5);
    rdchk("t4_status", A_STATUS, 32'h12 | (m ? 32'h04 : 32'h08));

    // Test 5: unreflected, zero-init, no final XOR; then START|END together
    wr(A_CONFIG, 32'h0, 2'b00);
    wr(A_POLY, POLY0, 2'b10);
    e = ref_crc(msg, 3'b000, POLY0);
    f = msg;
    for (int b = 0; b < 4; b++) f.push_back(e[8*b +: 8]);
    run_frame("t5", f);
    rdchk("t5_status", A_STATUS, 32'h06);
    rdchk("t5_calc", A_CALC, e);
    wr(A_CTRL, 32'h3, 2'b00);
    repeat (3) @(negedge clk);
    rdchk("t5_active", A_STATUS, 32'h01);
    rd(A_CALC, d, r);
    chk("t5_rdy", {31'h0, r}, 32'h1);
    wr(A_CONFIG, 32'h7, 2'b00);
    rdchk("t5_cfg_locked", A_CONFIG, 32'h0);

    // Byte-lane writes to POLY
    wr(A_POLY, 32'h12345678, 2'b10);
    wr(A_POLY, 32'hFFFFAAAA, 2'b01);
    rdchk("poly_16", A_POLY, 32'h1234AAAA);
    wr(A_POLY, 32'hFFFFFF55, 2'b00);
    rdchk("poly_8", A_POLY, 32'h1234AA55);

    // Test 6: reset in the middle of byte processing
    wr(A_CTRL, 32'h1, 2'b00);
    f = {};
    repeat (5) f.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) begin wr(A_DATA, {24'h0, f[i]}, 2'b00); repeat (10) @(negedge clk); end
    wr(A_DATA, {24'h0, f[4]}, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("t6_status", A_STATUS, 32'h0);
    rdchk("t6_poly", A_POLY, POLY0);
    rdchk("t6_config", A_CONFIG, 32'h7);
    rdchk("t6_len", A_LEN, 32'h0);
    rdchk("t6_calc", A_CALC, 32'h0);
    chk("t6_irq", {31'h0, user_interrupt}, 32'h0);
    chk("t6_uo", {24'h0, uo_out}, 32'h0);
    f = msg; f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    run_frame("t6", f);
    rdchk("t6_frame_status", A_STATUS, 32'h06);
    rdchk("t6_frame_calc", A_CALC, 32'hCBF43926);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
